// File: rtl/n_bit_divider.sv
// Sequential restoring divider: one quotient bit per clock, trial subtraction
// done by an N_BITS+1 wide ripple adder with inverted divisor and carry-in.
module n_bit_adder #(
    parameter int N_BITS = 4
) (
    input  logic [N_BITS-1:0] i_a,
    input  logic [N_BITS-1:0] i_b,
    input  logic              i_carryin,
    output logic [N_BITS-1:0] o_sum,
    output logic              o_carryout
);
    assign {o_carryout, o_sum} = {1'b0, i_a} + {1'b0, i_b}
                               + {{N_BITS{1'b0}}, i_carryin};
endmodule

module n_bit_divider #(
    parameter int N_BITS = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [N_BITS-1:0] i_dividend,
    input  logic [N_BITS-1:0] i_divisor,
    output logic [N_BITS-1:0] o_quotient,
    output logic [N_BITS-1:0] o_remainder,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_div_by_zero
);
    localparam int CW = $clog2(N_BITS + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nx;
    logic [N_BITS:0]   rem, rem_nx;
    logic [N_BITS-1:0] quo, quo_nx;
    logic [N_BITS-1:0] dvs, dvs_nx;
    logic [CW-1:0]     count, count_nx;
    logic [N_BITS-1:0] q_out_nx, r_out_nx;
    logic              busy_nx, done_nx, dbz_nx;

    logic [N_BITS:0]   shifted, diff;
    logic              ge;

    assign shifted = {rem[N_BITS-1:0], quo[N_BITS-1]};

    // carry out of Rs + ~D + 1 is set exactly when Rs >= D
    n_bit_adder #(.N_BITS(N_BITS + 1)) u_sub (
        .i_a       (shifted),
        .i_b       (~{1'b0, dvs}),
        .i_carryin (1'b1),
        .o_sum     (diff),
        .o_carryout(ge)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            rem           <= '0;
            quo           <= '0;
            dvs           <= '0;
            count         <= '0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_div_by_zero <= 1'b0;
        end else begin
            state         <= state_nx;
            rem           <= rem_nx;
            quo           <= quo_nx;
            dvs           <= dvs_nx;
            count         <= count_nx;
            o_quotient    <= q_out_nx;
            o_remainder   <= r_out_nx;
            o_busy        <= busy_nx;
            o_done        <= done_nx;
            o_div_by_zero <= dbz_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        quo_nx   = quo;
        dvs_nx   = dvs;
        count_nx = count;
        q_out_nx = o_quotient;
        r_out_nx = o_remainder;
        busy_nx  = o_busy;
        done_nx  = 1'b0;
        dbz_nx   = o_div_by_zero;
        unique case (state)
            IDLE: begin
                if (i_start) begin
                    if (i_divisor == '0) begin
                        q_out_nx = '1;
                        r_out_nx = i_dividend;
                        dbz_nx   = 1'b1;
                        done_nx  = 1'b1;
                    end else begin
                        dvs_nx   = i_divisor;
                        quo_nx   = i_dividend;
                        rem_nx   = '0;
                        count_nx = '0;
                        state_nx = RUN;
                        busy_nx  = 1'b1;
                        dbz_nx   = 1'b0;
                    end
                end
            end
            RUN: begin
                rem_nx   = ge ? diff : shifted;
                quo_nx   = {quo[N_BITS-2:0], ge};
                count_nx = count + CW'(1);
                if (count == CW'(N_BITS - 1)) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    q_out_nx = quo_nx;
                    r_out_nx = rem_nx[N_BITS-1:0];
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_n_bit_divider.sv
// Self-checking bench for n_bit_divider (N_BITS=4): directed table,
// ignored start, async reset mid-run and exhaustive back-to-back sweep.
module tb_n_bit_divider;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic [N-1:0] quotient, remainder;
    logic         busy, done, dbz;

    int checks = 0;
    int fails = 0;
    int done_cnt = 0;
    logic [N-1:0] prev_q = '0;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         z;
        int           poke;
    } vec_t;

    n_bit_divider #(.N_BITS(N)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_dividend   (dividend),
        .i_divisor    (divisor),
        .o_quotient   (quotient),
        .o_remainder  (remainder),
        .o_busy       (busy),
        .o_done       (done),
        .o_div_by_zero(dbz)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where o_done is seen so
    // the next call starts in the done cycle.
    task automatic run(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] eq, input logic [N-1:0] er,
                       input logic ez, input int poke);
        int cyc = 0;
        int busy_cyc = 0;
        bit seen = 0;
        start = 1'b1;
        dividend = a;
        divisor = b;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == poke) begin
                start = 1'b1;
                dividend = 1;
                divisor = 1;
            end else begin
                start = 1'b0;
                dividend = N'($urandom);
                divisor = N'($urandom);
            end
            if (busy === 1'b1) busy_cyc++;
            if (cyc == 2 && !ez) check("hold_q", quotient, prev_q);
            if (done === 1'b1) seen = 1;
        end
        check("done_seen", seen, 1);
        check("latency", cyc, ez ? 1 : N + 1);
        check("busy_cycles", busy_cyc, ez ? 0 : N);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("dbz", dbz, ez);
        prev_q = eq;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{4'd13, 4'd4, 4'd3,  4'd1, 1'b0, 0};
        vecs[1] = '{4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 0};
        vecs[2] = '{4'd3,  4'd7, 4'd0,  4'd3, 1'b0, 0};
        vecs[3] = '{4'd9,  4'd0, 4'd15, 4'd9, 1'b1, 0};
        vecs[4] = '{4'd12, 4'd5, 4'd2,  4'd2, 1'b0, 1};
        vecs[5] = '{4'd0,  4'd5, 4'd0,  4'd0, 1'b0, 0};
        vecs[6] = '{4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 0};
        vecs[7] = '{4'd8,  4'd3, 4'd2,  4'd2, 1'b0, 2};
        vecs[8] = '{4'd0,  4'd0, 4'd15, 4'd0, 1'b1, 0};

        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", dbz, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                vecs[i].z, vecs[i].poke);

        // asynchronous reset in the middle of a division
        start = 1'b1;
        dividend = 4'd14;
        divisor = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_q", quotient, 0);
        check("arst_r", remainder, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_dbz", dbz, 0);
        done_cnt = 0;
        repeat (6) @(negedge clk);
        check("arst_no_done", done_cnt, 0);
        rst_n = 1'b1;
        prev_q = '0;
        run(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 0);

        repeat (2) @(negedge clk);
        done_cnt = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [N-1:0] av, bv, mq, mr;
                av = N'(a);
                bv = N'(b);
                mq = (b == 0) ? 4'hF : N'(a / b);
                mr = (b == 0) ? av : N'(a % b);
                run(av, bv, mq, mr, b == 0, 0);
            end
        end
        repeat (3) @(negedge clk);
        check("done_count", done_cnt, 256);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
